// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes an N-bit Johnson bus to a binary phase index,
// flags illegal codes and out-of-sequence steps, and tracks lock via a small FSM.
module johnson_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int CW       = 8,
  localparam int IW      = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [0:N-1]  jc_in,
  output logic [IW-1:0] idx,
  output logic          idx_valid,
  output logic          code_err,
  output logic          seq_err,
  output logic          locked,
  output logic [CW-1:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [IW:0]   TWO_N       = (IW+1)'(2*N);
  localparam logic [IW-1:0] LAST_IDX    = IW'(2*N-1);
  localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_CNT);
  localparam logic [CW-1:0] ERR_MAX     = '1;

  state_t        r_state, w_nextState;
  logic [3:0]    r_run, w_nextRun;
  logic [IW-1:0] r_prev, w_nextPrev;
  logic [IW-1:0] r_idx, w_nextIdx;
  logic [IW-1:0] w_decIdx, w_succ;
  logic [IW:0]   w_pop, w_diffCnt;
  logic          w_legal, w_idxValid, w_codeErr, w_seqErr;
  logic          r_idxValid, r_codeErr, r_seqErr, r_locked;
  logic [CW-1:0] r_errCnt, w_nextErrCnt;

  // A legal Johnson word has at most one boundary between its run of ones and zeros.
  always_comb begin
    w_pop     = '0;
    w_diffCnt = '0;
    for (int i = 0; i < N; i++)
      w_pop = w_pop + {{IW{1'b0}}, jc_in[i]};
    for (int i = 0; i < N-1; i++)
      w_diffCnt = w_diffCnt + {{IW{1'b0}}, jc_in[i] ^ jc_in[i+1]};
    w_legal = (w_diffCnt <= (IW+1)'(1));
    if (jc_in[0])
      w_decIdx = w_pop[IW-1:0];
    else if (w_pop == '0)
      w_decIdx = '0;
    else
      w_decIdx = IW'(TWO_N - w_pop);
    w_succ = (r_prev == LAST_IDX) ? '0 : r_prev + 1'b1;
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextRun    = r_run;
    w_nextPrev   = r_prev;
    w_nextIdx    = r_idx;
    w_idxValid   = 1'b0;
    w_codeErr    = 1'b0;
    w_seqErr     = 1'b0;
    w_nextErrCnt = r_errCnt;
    if (clr) begin
      w_nextState  = SEARCH;
      w_nextRun    = '0;
      w_nextErrCnt = '0;
    end else if (in_valid) begin
      if (!w_legal) begin
        w_codeErr   = 1'b1;
        w_nextState = SEARCH;
      end else begin
        w_idxValid = 1'b1;
        w_nextIdx  = w_decIdx;
        w_nextPrev = w_decIdx;
        unique case (r_state)
          SEARCH: begin
            w_nextState = VERIFY;
            w_nextRun   = '0;
          end
          VERIFY: begin
            if (w_decIdx == w_succ) begin
              w_nextRun = r_run + 4'd1;
              if (r_run + 4'd1 == LOCK_TARGET)
                w_nextState = LOCKED;
            end else begin
              w_seqErr  = 1'b1;
              w_nextRun = '0;
            end
          end
          LOCKED: begin
            if (w_decIdx != w_succ) begin
              w_seqErr    = 1'b1;
              w_nextState = VERIFY;
              w_nextRun   = '0;
            end
          end
          default: w_nextState = SEARCH;
        endcase
      end
      if ((w_codeErr || w_seqErr) && r_errCnt != ERR_MAX)
        w_nextErrCnt = r_errCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEARCH;
      r_run      <= '0;
      r_prev     <= '0;
      r_idx      <= '0;
      r_idxValid <= 1'b0;
      r_codeErr  <= 1'b0;
      r_seqErr   <= 1'b0;
      r_locked   <= 1'b0;
      r_errCnt   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_run      <= w_nextRun;
      r_prev     <= w_nextPrev;
      r_idx      <= w_nextIdx;
      r_idxValid <= w_idxValid;
      r_codeErr  <= w_codeErr;
      r_seqErr   <= w_seqErr;
      r_locked   <= (w_nextState == LOCKED);
      r_errCnt   <= w_nextErrCnt;
    end
  end

  assign idx       = r_idx;
  assign idx_valid = r_idxValid;
  assign code_err  = r_codeErr;
  assign seq_err   = r_seqErr;
  assign locked    = r_locked;
  assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed-vector bench for johnson_decoder (N=4, LOCK_CNT=3, CW=8) with
// hand-computed expected outputs after each clock edge.
module tb_johnson_decoder;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [0:3] jc_in;
  logic [2:0] idx;
  logic       idx_valid;
  logic       code_err;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_cnt;

  int testCount = 0;
  int failCount = 0;

  johnson_decoder #(.N(4), .LOCK_CNT(3), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .jc_in     (jc_in),
    .idx       (idx),
    .idx_valid (idx_valid),
    .code_err  (code_err),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one sample and advance past the sampling edge.
  task automatic applyStimulus(input logic v, input logic [0:3] code, input logic c);
    in_valid = v;
    jc_in    = code;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int eIdx, input int eIv,
                          input int eCe, input int eSe, input int eLk, input int eEc);
    checkOutput({tag, ".idx"},       32'(idx),       32'(eIdx));
    checkOutput({tag, ".idx_valid"}, 32'(idx_valid), 32'(eIv));
    checkOutput({tag, ".code_err"},  32'(code_err),  32'(eCe));
    checkOutput({tag, ".seq_err"},   32'(seq_err),   32'(eSe));
    checkOutput({tag, ".locked"},    32'(locked),    32'(eLk));
    checkOutput({tag, ".err_cnt"},   32'(err_cnt),   32'(eEc));
  endtask

  task automatic step(input string tag, input logic [0:3] code, input int eIdx,
                      input int eIv, input int eCe, input int eSe, input int eLk,
                      input int eEc);
    applyStimulus(1'b1, code, 1'b0);
    checkAll(tag, eIdx, eIv, eCe, eSe, eLk, eEc);
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    jc_in    = 4'b0000;

    // Reset held while samples are offered.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0], 4'b1000, 1'b0);
      checkAll("rst_hold", 0, 0, 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkAll("rst_idle", 0, 0, 0, 0, 0, 0);
    end

    // Acquisition: locks on the third correct successor.
    step("acq0", 4'b0000, 0, 1, 0, 0, 0, 0);
    step("acq1", 4'b1000, 1, 1, 0, 0, 0, 0);
    step("acq2", 4'b1100, 2, 1, 0, 0, 0, 0);
    step("acq3", 4'b1110, 3, 1, 0, 0, 1, 0);
    step("acq4", 4'b1111, 4, 1, 0, 0, 1, 0);

    // Wrap through 7 -> 0 while locked.
    step("wrap5", 4'b0111, 5, 1, 0, 0, 1, 0);
    step("wrap6", 4'b0011, 6, 1, 0, 0, 1, 0);
    step("wrap7", 4'b0001, 7, 1, 0, 0, 1, 0);
    step("wrap0", 4'b0000, 0, 1, 0, 0, 1, 0);
    step("wrap1", 4'b1000, 1, 1, 0, 0, 1, 0);

    // Illegal code drops lock, idx held.
    step("ill",      4'b1010, 1, 0, 1, 0, 0, 1);
    step("ill_next", 4'b0000, 0, 1, 0, 0, 0, 1);

    // Relock, then skip from 2 to 4.
    step("rl1", 4'b1000, 1, 1, 0, 0, 0, 1);
    step("rl2", 4'b1100, 2, 1, 0, 0, 0, 1);
    step("rl3", 4'b1110, 3, 1, 0, 0, 1, 1);
    step("rl4", 4'b1111, 4, 1, 0, 0, 1, 1);
    step("rl5", 4'b0111, 5, 1, 0, 0, 1, 1);
    step("rl6", 4'b0011, 6, 1, 0, 0, 1, 1);
    step("rl7", 4'b0001, 7, 1, 0, 0, 1, 1);
    step("rl0", 4'b0000, 0, 1, 0, 0, 1, 1);
    step("rl1b", 4'b1000, 1, 1, 0, 0, 1, 1);
    step("rl2b", 4'b1100, 2, 1, 0, 0, 1, 1);
    step("skip", 4'b1111, 4, 1, 0, 1, 0, 2);
    step("sk5",  4'b0111, 5, 1, 0, 0, 0, 2);
    step("sk6",  4'b0011, 6, 1, 0, 0, 0, 2);
    step("sk7",  4'b0001, 7, 1, 0, 0, 1, 2);

    // Gap in in_valid: nothing moves, sequence continues afterwards.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1010, 1'b0);
      checkAll("gap", 7, 0, 0, 0, 1, 2);
    end
    step("gap_end", 4'b0000, 0, 1, 0, 0, 1, 2);

    // Upstream restart to 0 is a wrong successor.
    step("rs1", 4'b1000, 1, 1, 0, 0, 1, 2);
    step("rs0", 4'b0000, 0, 1, 0, 1, 0, 3);
    step("rs1b", 4'b1000, 1, 1, 0, 0, 0, 3);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 4'b1010, 1'b0);
      if (i == 99) checkAll("sat100", 1, 0, 1, 0, 0, 103);
    end
    checkAll("sat", 1, 0, 1, 0, 0, 255);

    // clr wins over a coincident sample.
    applyStimulus(1'b1, 4'b1100, 1'b1);
    checkAll("clr", 1, 0, 0, 0, 0, 0);
    step("clr_srch", 4'b0011, 6, 1, 0, 0, 0, 0);
    step("clr_vrfy", 4'b1000, 1, 1, 0, 1, 0, 1);

    // Asynchronous reset mid-run, checked before any clock edge.
    step("pre_rst", 4'b1100, 2, 1, 0, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    checkAll("async_rst", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    step("post_rst", 4'b1110, 3, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the team's Johnson counter: samples an N-bit Johnson-coded bus and decodes it to a binary phase index 0..2N-1. Flags illegal codes (any of the 2^N-2N invalid states) and out-of-sequence steps. Runs a lock state machine so downstream logic can trust the index only after a clean run of successors. Sits wherever a Johnson-coded phase or timing bus crosses into binary-consuming logic.

## Interface

Parameters:
- N, 4: Johnson code width (N >= 2); 2N valid states.
- LOCK_CNT, 3: consecutive correct successors required to reach LOCKED (1..15).
- CW, 8: width of the saturating error counter.

Ports (IW = $clog2(2N)):
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- clr  input  1  synchronous clear: forces SEARCH and zeroes err_cnt.
- in_valid  input  1  jc_in is sampled on this edge.
- jc_in  input  [0:N-1]  Johnson code. Bit 0 receives ~bit N-1 on each step; the sequence for N=4 as bits 0..3 is 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then back to 0000.
- idx  output  IW  decoded index of the last valid sample.
- idx_valid  output  1  one-cycle pulse: idx was updated from a valid code.
- code_err  output  1  one-cycle pulse: sampled code was illegal.
- seq_err  output  1  one-cycle pulse: valid code that is not the expected successor (VERIFY/LOCKED only).
- locked  output  1  high while the FSM is in LOCKED.
- err_cnt  output  CW  saturating count of code_err plus seq_err pulses.

## Operation

- Legality: the code is legal iff at most one adjacent pair (i, i+1) differs, for i = 0..N-2.
- Decode (legal codes only), with k = popcount(jc_in):
  - jc_in[0]=1 gives index k.
  - jc_in[0]=0 and k=0 gives index 0.
  - jc_in[0]=0 and k>0 gives index 2N-k.
- Expected successor: (prev + 1) mod 2N, so 2N-1 is followed by 0.
- The FSM has states SEARCH, VERIFY and LOCKED, plus a run counter `run` and a reference index `prev`.
  - SEARCH:
    - Legal sample: go to VERIFY, set prev to the decoded index, set run=0.
    - Illegal sample: code_err, stay in SEARCH.
  - VERIFY:
    - Correct successor: run+1, prev updated. Go to LOCKED when run+1 == LOCK_CNT.
    - Legal but wrong: seq_err, stay in VERIFY, prev set to the new index, run=0.
    - Illegal: code_err, go to SEARCH.
  - LOCKED:
    - Correct successor: stay, prev updated.
    - Legal but wrong: seq_err, go to VERIFY, prev set to the new index, run=0.
    - Illegal: code_err, go to SEARCH.
- Every legal sample updates idx and pulses idx_valid, including those that raise seq_err.
- An illegal sample leaves idx unchanged.
- in_valid=0: no state change; all pulse outputs are 0.
- clr: overrides a coincident in_valid, so that sample is dropped with no pulses. Result is SEARCH, run=0, err_cnt=0; idx is held.
- err_cnt: increments by 1 on each error pulse and holds at 2^CW-1. code_err and seq_err are mutually exclusive.

## Timing

- Reset (rst_n low, asynchronous) gives:
  - idx=0, idx_valid=0, code_err=0, seq_err=0, locked=0, err_cnt=0.
  - State SEARCH, run=0, prev=0.
- All outputs are registered. A sample taken at edge t is reflected in the outputs from edge t until edge t+1 (latency 1).
- locked rises at the same edge as the idx_valid pulse of the LOCK_CNT-th correct successor.
- locked falls at the same edge as the error pulse that causes it.
- rst_n asserted mid-run: immediate return to reset values; sampling resumes on the first edge after release.
- An upstream counter restarting to 0 mid-sequence is a wrong successor. Required response: seq_err and drop to VERIFY; 0 is not treated as legal re-entry.

## Test plan

1. Reset: hold rst_n=0 with in_valid toggling -> all outputs 0. Release, no input -> outputs stay 0.
2. Acquisition (N=4, LOCK_CNT=3): feed 0000, 1000, 1100, 1110, 1111 on consecutive cycles -> idx 0,1,2,3,4 with idx_valid each cycle. locked=1 from the 1110 output cycle. No errors.
3. Wrap: while locked feed 0011, 0001, 0000, 1000 -> idx 6,7,0,1. locked stays 1, seq_err never fires.
4. Illegal code: while locked feed 1010 -> code_err pulse, idx_valid=0, idx unchanged, locked=0, err_cnt=1. Next 0000 -> VERIFY, no error.
5. Skip: locked at idx 2, feed 1111 -> seq_err, idx=4, locked=0. Then 0111, 0011, 0001 -> relock on the 0001 cycle.
6. Gaps, saturation and clear:
   - in_valid low for 5 cycles mid-sequence -> state held, no pulses.
   - Force 300 illegal samples with CW=8 -> err_cnt=255.
   - clr together with in_valid -> err_cnt=0, SEARCH, no pulses.
